// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the shared-ALU controller: op codes, one-hot ALU
// op constants and the controller state encoding.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MOV = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_NOT = 3'd5,
    OP_CMP = 3'd6,
    OP_ILL = 3'd7
  } op_e;

  localparam logic [6:0] ALU_NOP = 7'b0000000;
  localparam logic [6:0] ALU_MOV = 7'b0000001;
  localparam logic [6:0] ALU_ADD = 7'b0000010;
  localparam logic [6:0] ALU_SUB = 7'b0000100;
  localparam logic [6:0] ALU_AND = 7'b0001000;
  localparam logic [6:0] ALU_OR  = 7'b0010000;
  localparam logic [6:0] ALU_NOT = 7'b0100000;
  // Compare also lights the MOV/ADD/SUB lanes so the ALU subtracts while comparing.
  localparam logic [6:0] ALU_CMP = 7'b1000111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Translate a requester op code into the ALU's one-hot control word.
  function automatic logic [6:0] op_to_alu(input op_e op);
    logic [6:0] v;
    case (op)
      OP_MOV:  v = ALU_MOV;
      OP_ADD:  v = ALU_ADD;
      OP_SUB:  v = ALU_SUB;
      OP_AND:  v = ALU_AND;
      OP_OR:   v = ALU_OR;
      OP_NOT:  v = ALU_NOT;
      OP_CMP:  v = ALU_CMP;
      default: v = ALU_NOP;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first requesting index at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       index,
  output logic             any
);

  // Scan from ptr upward; the first hit wins and later hits are ignored.
  always_comb begin
    int w_idx;
    grant = '0;
    index = 2'd0;
    any   = 1'b0;
    w_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = (int'(ptr) + k) % N_REQ;
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        grant[w_idx] = 1'b1;
        index        = w_idx[1:0];
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Arbitrates N_REQ requesters onto one external combinational ALU:
// grant in IDLE, drive the ALU for one EXEC cycle, hold the result in RESP.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [3*N_REQ-1:0]      req_op,
  input  logic [DATA_W*N_REQ-1:0] req_a,
  input  logic [DATA_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [1:0]              resp_id,
  output logic [DATA_W-1:0]       resp_result,
  output logic                    resp_eq,
  output logic                    resp_err,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [6:0]              alu_op,
  input  logic [DATA_W-1:0]       alu_result,
  input  logic                    alu_eq
);

  state_e              r_state;
  state_e              w_state_next;
  logic [1:0]          r_ptr;
  logic [1:0]          r_grant_idx;
  op_e                 r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_resp_result;
  logic                r_resp_eq;
  logic                r_resp_err;
  logic [N_REQ-1:0]    w_grant;
  logic [1:0]          w_grant_idx;
  logic                w_any;
  logic                w_accept;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .index (w_grant_idx),
    .any   (w_any)
  );

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state plus the combinational grant and ALU drive.
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    w_accept     = 1'b0;
    alu_op       = ALU_NOP;
    alu_a        = '0;
    alu_b        = '0;
    case (r_state)
      ST_IDLE: begin
        // rst_n gates the grant so nothing looks accepted while held in reset.
        if (w_any && rst_n) begin
          req_ready    = w_grant;
          w_accept     = 1'b1;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op       = op_to_alu(r_op);
        alu_a        = r_a;
        alu_b        = r_b;
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Latch the granted request, then capture the ALU outcome at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr         <= 2'd0;
      r_grant_idx   <= 2'd0;
      r_op          <= OP_MOV;
      r_a           <= '0;
      r_b           <= '0;
      r_resp_result <= '0;
      r_resp_eq     <= 1'b0;
      r_resp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_grant_idx <= w_grant_idx;
        r_op        <= op_e'(req_op[3*w_grant_idx +: 3]);
        r_a         <= req_a[DATA_W*w_grant_idx +: DATA_W];
        r_b         <= req_b[DATA_W*w_grant_idx +: DATA_W];
      end
      if (r_state == ST_EXEC) begin
        r_ptr         <= (r_grant_idx == 2'(N_REQ - 1)) ? 2'd0 : r_grant_idx + 2'd1;
        r_resp_err    <= (r_op == OP_ILL);
        // Only a compare reports equality; compare and illegal ops return zero data.
        r_resp_eq     <= (r_op == OP_CMP) ? alu_eq : 1'b0;
        r_resp_result <= (r_op == OP_CMP || r_op == OP_ILL) ? '0 : alu_result;
      end
    end
  end

  assign resp_valid  = (r_state == ST_RESP);
  assign resp_id     = r_grant_idx;
  assign resp_result = r_resp_result;
  assign resp_eq     = r_resp_eq;
  assign resp_err    = r_resp_err;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural ALU attached.
module tb_alu_share_ctrl;

  localparam int N  = 2;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [3*N-1:0]  req_op;
  logic [DW*N-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic            resp_valid, resp_ready;
  logic [1:0]      resp_id;
  logic [DW-1:0]   resp_result;
  logic            resp_eq, resp_err;
  logic [DW-1:0]   alu_a, alu_b, alu_result;
  logic [6:0]      alu_op;
  logic            alu_eq;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] res;
    logic          eq;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_eq(resp_eq), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_eq(alu_eq)
  );

  // Behavioural ALU; eq always reflects a==b so the controller must mask it.
  always_comb begin
    alu_eq = (alu_a == alu_b);
    case (alu_op)
      7'b0000001: alu_result = alu_a;
      7'b0000010: alu_result = alu_a + alu_b;
      7'b0000100: alu_result = alu_a - alu_b;
      7'b0001000: alu_result = alu_a & alu_b;
      7'b0010000: alu_result = alu_a | alu_b;
      7'b0100000: alu_result = ~alu_a;
      7'b1000111: alu_result = alu_a - alu_b;
      default:    alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_onehot(input logic [2:0] op);
    case (op)
      3'd0: return 7'b0000001;
      3'd1: return 7'b0000010;
      3'd2: return 7'b0000100;
      3'd3: return 7'b0001000;
      3'd4: return 7'b0010000;
      3'd5: return 7'b0100000;
      3'd6: return 7'b1000111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic exp_t golden(input int id, input logic [2:0] op,
                                  input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    e.id = 2'(id); e.res = '0; e.eq = 1'b0; e.err = 1'b0;
    case (op)
      3'd0: e.res = a;
      3'd1: e.res = a + b;
      3'd2: e.res = a - b;
      3'd3: e.res = a & b;
      3'd4: e.res = a | b;
      3'd5: e.res = ~a;
      3'd6: e.eq  = (a == b);
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Scoreboard: push at acceptance, pop and compare at response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ready != '0) begin
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        for (int i = 0; i < N; i++)
          if (req_ready[i] && req_valid[i])
            exp_q.push_back(golden(i, req_op[3*i +: 3], req_a[DW*i +: DW], req_b[DW*i +: DW]));
      end
      if (resp_valid && resp_ready) begin
        $display("resp id=%0d result=%h eq=%0b err=%0b", resp_id, resp_result, resp_eq, resp_err);
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_id",     32'(resp_id),     32'(mon_e.id));
          chk("resp_result", 32'(resp_result), 32'(mon_e.res));
          chk("resp_eq",     32'(resp_eq),     32'(mon_e.eq));
          chk("resp_err",    32'(resp_err),    32'(mon_e.err));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    exp_q.delete();
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int r, input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_op[3*r +: 3]  = op;
    req_a[DW*r +: DW] = a;
    req_b[DW*r +: DW] = b;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rvalid"}, 32'(resp_valid),  32'd0);
    chk({tag, "_rid"},    32'(resp_id),     32'd0);
    chk({tag, "_rres"},   32'(resp_result), 32'd0);
    chk({tag, "_req"},    32'(resp_eq),     32'd0);
    chk({tag, "_rerr"},   32'(resp_err),    32'd0);
    chk({tag, "_aluop"},  32'(alu_op),      32'd0);
    chk({tag, "_alua"},   32'(alu_a),       32'd0);
    chk({tag, "_alub"},   32'(alu_b),       32'd0);
    chk({tag, "_ready"},  32'(req_ready),   32'd0);
  endtask

  // One isolated request: grant in cycle 0, ALU drive in cycle 1, response in cycle 2.
  task automatic run_one(input int r, input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    set_req(r, op, a, b);
    resp_ready = 1'b1;
    req_valid  = N'(32'd1 << r);
    @(negedge clk);
    chk("grant", 32'(req_ready), 32'd1 << r);
    chk("idle_aluop", 32'(alu_op), 32'd0);
    tick;
    req_valid = '0;
    set_req(r, 3'(($urandom % 7)), 16'($urandom), 16'($urandom));
    @(negedge clk);
    chk("exec_aluop", 32'(alu_op), 32'(exp_onehot(op)));
    chk("exec_a",     32'(alu_a),  32'(a));
    chk("exec_b",     32'(alu_b),  32'(b));
    chk("exec_ready", 32'(req_ready), 32'd0);
    tick;
    @(negedge clk);
    chk("resp_latency", 32'(resp_valid), 32'd1);
    tick;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_op = '0; req_a = '0; req_b = '0;
    resp_ready = 1'b0;
    #2;
    check_all_zero("rst");
    tick; tick;
    check_all_zero("rst2");
    req_valid = '0;
    resp_ready = 1'b1;
    rst_n = 1'b1;

    run_one(0, 3'd1, 16'hFFFF, 16'h0002);
    run_one(1, 3'd6, 16'h1234, 16'h1234);
    run_one(1, 3'd2, 16'h0005, 16'h0003);
    run_one(0, 3'd1, 16'h0007, 16'h0007);
    run_one(1, 3'd7, 16'h5555, 16'h5555);
    for (int op = 0; op < 7; op++)
      run_one(op % 2, 3'(op), 16'($urandom), 16'($urandom));

    // Both requesters held valid: grants alternate every third cycle.
    do_reset();
    set_req(0, 3'd1, 16'h0001, 16'h0002);
    set_req(1, 3'd4, 16'h00F0, 16'h000F);
    req_valid = 2'b11;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("rr_c%0d", c), 32'(req_ready),
          (c % 3 != 0) ? 32'd0 : (((c / 3) % 2 == 0) ? 32'd1 : 32'd2));
      tick;
    end
    req_valid = '0;

    // Consumer stalls for four cycles while both requesters keep asking.
    do_reset();
    set_req(0, 3'd0, 16'hABCD, 16'h0000);
    set_req(1, 3'd3, 16'h00FF, 16'h0F0F);
    resp_ready = 1'b0;
    req_valid  = 2'b11;
    @(negedge clk);
    chk("stall_grant", 32'(req_ready), 32'd1);
    tick;
    @(negedge clk);
    chk("stall_exec_ready", 32'(req_ready), 32'd0);
    tick;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_valid",  32'(resp_valid),  32'd1);
      chk("stall_id",     32'(resp_id),     32'd0);
      chk("stall_result", 32'(resp_result), 32'hABCD);
      chk("stall_err",    32'(resp_err),    32'd0);
      chk("stall_ready",  32'(req_ready),   32'd0);
      tick;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", 32'(resp_valid), 32'd1);
    tick;
    @(negedge clk);
    chk("stall_next_grant", 32'(req_ready), 32'd2);
    tick;
    req_valid = '0;
    @(negedge clk);
    tick;
    @(negedge clk);
    chk("stall_next_resp", 32'(resp_valid), 32'd1);
    tick;

    // Reset asserted mid-response: outputs clear at once and nothing is delivered.
    set_req(0, 3'd4, 16'h0001, 16'h0002);
    resp_ready = 1'b0;
    req_valid  = 2'b01;
    @(negedge clk);
    chk("abort_grant", 32'(req_ready), 32'd1);
    tick;
    @(negedge clk);
    tick;
    @(negedge clk);
    chk("abort_in_resp", 32'(resp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    exp_q.delete();
    req_valid = '0;
    resp_ready = 1'b1;
    tick; tick;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
      tick;
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 Parameter N_REQ, default 2, number of requesters sharing the ALU (2..4).
REQ-002 Parameter DATA_W, default 16, operand/result width.
REQ-003 Port clk  input  1  single clock, all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port req_valid  input  N_REQ  per-requester operation request.
REQ-006 Port req_op  input  3*N_REQ  per-requester op code, requester i in bits [3i+2:3i].
REQ-007 Port req_a, req_b  input  DATA_W*N_REQ  per-requester operands i and j, requester i in slice i.
REQ-008 Port req_ready  output  N_REQ  grant/accept, at most one bit set.
REQ-009 Port resp_valid  output  1  result available.
REQ-010 Port resp_ready  input  1  consumer accepts result.
REQ-011 Port resp_id  output  2  index of requester owning the result.
REQ-012 Port resp_result, resp_eq, resp_err  output  DATA_W, 1, 1  result, equality flag, illegal-op flag.
REQ-013 Port alu_a, alu_b  output  DATA_W  operands to the shared ALU.
REQ-014 Port alu_op  output  7  one-hot ALU opcode.
REQ-015 Port alu_result, alu_eq  input  DATA_W, 1  ALU outputs, combinational from alu_a/alu_b/alu_op.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-017 IDLE with any req_valid: grant = first set bit scanning from ptr upward, wrapping mod N_REQ; req_ready[grant] SHALL be 1 combinationally that cycle; op, a, b, grant latched; next state EXEC.
REQ-018 req_ready SHALL be all-zero in EXEC and RESP and in IDLE with no req_valid.
REQ-019 EXEC (exactly 1 cycle): alu_a/alu_b/alu_op driven from latched regs; alu_result/alu_eq captured into response regs at end of cycle; ptr <= (grant+1) mod N_REQ; next state RESP.
REQ-020 alu_op SHALL be 7'b0000000 and alu_a/alu_b SHALL be 0 outside EXEC.
REQ-021 Op mapping: 0 MOV->0000001, 1 ADD->0000010, 2 SUB->0000100, 3 AND->0001000, 4 OR->0010000, 5 NOT->0100000, 6 CMP->1000111.
REQ-022 Op 7 illegal: alu_op stays 0 in EXEC; response result 0, eq 0, err 1.
REQ-023 CMP: resp_result 0, resp_eq = captured alu_eq; non-CMP: resp_eq forced 0 regardless of alu_eq.
REQ-024 ADD/SUB wrap modulo 2^DATA_W; no carry/overflow reported.
REQ-025 RESP: resp_valid 1; resp_id/result/eq/err stable until resp_valid&resp_ready; then next state IDLE.
REQ-026 No grant in the RESP cycle; minimum issue interval 3 cycles; request-to-response latency 2 cycles.
REQ-027 req_valid deasserted before grant: no acceptance, no state change.
REQ-028 req_op/req_a/req_b changes after acceptance SHALL not affect the in-flight operation.

Reset
REQ-029 rst_n low SHALL immediately set state IDLE, ptr 0, resp_valid 0, resp_id/result/eq/err 0, alu_op/alu_a/alu_b 0, req_ready 0.
REQ-030 Reset during EXEC or RESP SHALL discard the in-flight operation with no response.

Structure
REQ-031 Shared package alu_ctrl_pkg holds op-code enum (3-bit), the seven one-hot ALU op constants, and the FSM state enum.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot grant, index, any).

Verification
REQ-033 rst_n=0 in RESP with resp_ready=0 -> all outputs 0 same cycle, no response after release.
REQ-034 Req0 ADD a=16'hFFFF b=16'h0002 -> req_ready[0] cycle 0, alu_op=0000010 cycle 1, resp_valid cycle 2 with result 16'h0001, eq 0, id 0.
REQ-035 Both valid continuously, ptr 0, resp_ready=1 -> grants alternate 0,1,0,1 every 3 cycles.
REQ-036 Req1 CMP a=b=16'h1234 -> result 0, eq 1; then SUB 5-3 -> result 2, eq 0.
REQ-037 Op 7 -> alu_op 0 in EXEC, result 0, err 1.
REQ-038 resp_ready low 4 cycles in RESP with req_valid high -> outputs held, req_ready 0 until return to IDLE.
